uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 i_ref_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_ret_n  input  1  reset, synchronous, active-low.
REQ-004 i_div_ratio  input  8  bit period in i_ref_clk cycles; sampled only when a frame is accepted.
REQ-005 i_data  input  DATA_WIDTH  byte to transmit.
REQ-006 i_data_valid  input  1  request; a frame is accepted on any edge where it is high and o_busy is low.
REQ-007 i_par_en  input  1  1 = append parity bit; sampled only at accept.
REQ-008 i_par_typ  input  1  0 = even, 1 = odd parity; sampled only at accept.
REQ-009 o_tx  output  1  serial line, idle high.
REQ-010 o_busy  output  1  high from the cycle after accept through the last stop-bit cycle.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: o_tx=1, o_busy=0; on accept, latch i_data, i_par_en, i_par_typ and the effective period, then go to START.
REQ-013 Effective period P SHALL equal i_div_ratio, except that 0 and 1 both give P=1 (bypass, one cycle per bit).
REQ-014 Each of START (o_tx=0), DATA, PARITY, STOP (o_tx=1) bits SHALL hold o_tx for exactly P cycles.
REQ-015 DATA SHALL shift out DATA_WIDTH bits, LSB first, with a bit index counter running 0..DATA_WIDTH-1.
REQ-016 After the last data bit: go to PARITY if latched par_en=1, else go to STOP.
REQ-017 Parity bit SHALL equal XOR of latched data for even, and its inverse for odd.
REQ-018 From STOP end: return to IDLE; if i_data_valid is high on that same edge, it is not accepted (acceptance requires o_busy low), so the minimum gap between frames is one idle cycle.
REQ-019 The first START cycle SHALL be the cycle immediately after accept (latency 1); frame length SHALL be (DATA_WIDTH+2+par_en)*P cycles.
REQ-020 While o_busy=1, i_data_valid and all config inputs SHALL be ignored; changes to them SHALL NOT alter the frame in progress.
REQ-021 The bit-period counter SHALL be 8 bits wide, count 1..P, and reload on each bit boundary; it SHALL never wrap through 0.
REQ-022 o_tx and o_busy SHALL be registered outputs (glitch-free).

Reset
REQ-023 When i_ret_n=0 at a clock edge: state=IDLE, o_tx=1, o_busy=0, counters=0, shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; o_tx SHALL be 1 from the cycle after the reset edge.
REQ-025 No output SHALL change asynchronously with i_ret_n.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state encoding, DATA_WIDTH default, and the parity-type constants PAR_EVEN=0, PAR_ODD=1.
REQ-027 The bit-period counter SHALL be a sub-module uart_baud_cnt (inputs: period, restart; output: bit_done pulse).

Verification
REQ-028 P=4, data 0xA5, par_en=1, even -> o_tx = 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles; o_busy high 44 cycles.
REQ-029 Same as REQ-028 with odd parity -> parity bit=1, all other bits identical.
REQ-030 i_div_ratio=0 and =1, data 0x00, par_en=0 -> 10-cycle frame, o_tx low 9 cycles then high 1.
REQ-031 Valid held high continuously with P=2, par_en=0 -> frames of 20 cycles separated by exactly 1 idle cycle; data changes during busy are not transmitted.
REQ-032 Reset asserted at cycle 7 of a P=4 frame -> o_tx=1, o_busy=0 from next cycle; the next accepted frame is complete and correct.
REQ-033 i_div_ratio changed from 4 to 8 mid-frame -> current frame keeps P=4; the following frame uses P=8.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, default frame
// width, parity-type constants and the divider-to-bit-period mapping.
package uart_pkg;

   localparam int   UART_DATA_WIDTH = 8;
   localparam logic PAR_EVEN        = 1'b0;
   localparam logic PAR_ODD         = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Dividers of 0 and 1 both mean one reference cycle per bit.
   function automatic logic [7:0] eff_period(input logic [7:0] div);
      return (div <= 8'd1) ? 8'd1 : div;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 1..period and pulses bit_done on the last cycle of
// each bit, reloading to 1 so it never passes through 0 while a frame runs.
module uart_baud_cnt (
   input  logic       i_ref_clk,
   input  logic       i_ret_n,
   input  logic [7:0] period,
   input  logic       restart,
   output logic       bit_done
);

   logic [7:0] cnt;

   assign bit_done = (cnt == period);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge i_ref_clk) begin
      if (!i_ret_n) begin
         cnt <= '0;
      end else if (restart || bit_done) begin
         cnt <= 8'd1;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit; every bit lasts P reference cycles; o_tx/o_busy are registered.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  i_ref_clk,
   input  logic                  i_ret_n,
   input  logic [7:0]            i_div_ratio,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_data_valid,
   input  logic                  i_par_en,
   input  logic                  i_par_typ,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int              IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   uart_state_e           state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [7:0]            period_q;
   logic                  par_en_q, par_bit_q;
   logic                  accept, restart, bit_done;
   logic                  tx_nxt, busy_nxt;

   uart_baud_cnt u_baud_cnt (
      .i_ref_clk (i_ref_clk),
      .i_ret_n   (i_ret_n),
      .period    (period_q),
      .restart   (restart),
      .bit_done  (bit_done)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      idx_nxt   = idx;
      accept    = 1'b0;
      restart   = 1'b0;
      tx_nxt    = 1'b1;
      busy_nxt  = 1'b1;

      unique case (state)
         ST_IDLE: begin
            restart = 1'b1;
            if (i_data_valid && !o_busy) begin
               accept    = 1'b1;
               state_nxt = ST_START;
               shreg_nxt = i_data;
               idx_nxt   = '0;
            end
         end
         ST_START: if (bit_done) state_nxt = ST_DATA;
         ST_DATA: begin
            if (bit_done) begin
               shreg_nxt = shreg >> 1;
               if (idx == LAST_IDX) begin
                  idx_nxt   = '0;
                  state_nxt = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         ST_PARITY: if (bit_done) state_nxt = ST_STOP;
         ST_STOP:   if (bit_done) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so the registers present the
      // new bit on the same edge the FSM moves.
      unique case (state_nxt)
         ST_IDLE:   busy_nxt = 1'b0;
         ST_START:  tx_nxt   = 1'b0;
         ST_DATA:   tx_nxt   = shreg_nxt[0];
         ST_PARITY: tx_nxt   = par_bit_q;
         default:   tx_nxt   = 1'b1;
      endcase
   end

   always_ff @(posedge i_ref_clk) begin
      if (!i_ret_n) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         idx       <= '0;
         period_q  <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         o_tx      <= 1'b1;
         o_busy    <= 1'b0;
      end else begin
         state  <= state_nxt;
         shreg  <= shreg_nxt;
         idx    <= idx_nxt;
         o_tx   <= tx_nxt;
         o_busy <= busy_nxt;
         if (accept) begin
            period_q  <= eff_period(i_div_ratio);
            par_en_q  <= i_par_en;
            par_bit_q <= (i_par_typ == PAR_EVEN) ? ^i_data : ~^i_data;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a frame-level model predicts o_tx/o_busy every cycle,
// and directed scenarios pin frame shape, timing and config isolation.
module tb_uart_tx_core;
   import uart_pkg::*;

   logic       i_ref_clk    = 1'b0;
   logic       i_ret_n      = 1'b0;
   logic [7:0] i_div_ratio  = 8'd4;
   logic [7:0] i_data       = 8'h00;
   logic       i_data_valid = 1'b0;
   logic       i_par_en     = 1'b0;
   logic       i_par_typ    = 1'b0;
   logic       o_tx, o_busy;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   uart_tx_core #(.DATA_WIDTH(8)) dut (
      .i_ref_clk    (i_ref_clk),
      .i_ret_n      (i_ret_n),
      .i_div_ratio  (i_div_ratio),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .i_par_en     (i_par_en),
      .i_par_typ    (i_par_typ),
      .o_tx         (o_tx),
      .o_busy       (o_busy)
   );

   always #5 i_ref_clk = ~i_ref_clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic exp_q[$];
   logic m_tx   = 1'b1;
   logic m_busy = 1'b0;

   task automatic push_frame(input logic [7:0] div, input logic [7:0] data,
                             input logic pe, input logic pt);
      int   p;
      logic b[$];
      p = (div <= 8'd1) ? 1 : int'(div);
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(data[i]);
      if (pe) b.push_back((^data) ^ pt);
      b.push_back(1'b1);
      foreach (b[k]) repeat (p) exp_q.push_back(b[k]);
   endtask

   always @(posedge i_ref_clk) begin
      if (!i_ret_n) begin
         exp_q.delete();
         m_tx   <= 1'b1;
         m_busy <= 1'b0;
      end else if (exp_q.size() > 0) begin
         m_tx   <= exp_q.pop_front();
         m_busy <= 1'b1;
      end else if (!m_busy && i_data_valid) begin
         push_frame(i_div_ratio, i_data, i_par_en, i_par_typ);
         m_tx   <= exp_q.pop_front();
         m_busy <= 1'b1;
      end else begin
         m_tx   <= 1'b1;
         m_busy <= 1'b0;
      end
   end

   always @(negedge i_ref_clk) begin
      if (chk_en) begin
         check("tx_cycle", 64'(o_tx), 64'(m_tx));
         check("busy_cycle", 64'(o_busy), 64'(m_busy));
      end
   end

   // ---------------- frame recorder ----------------
   typedef struct {
      int           len;
      int           gap;
      logic [511:0] bits;
   } frame_t;

   frame_t       frames[$];
   int           cur_len  = 0;
   int           cur_gap  = 0;
   int           idle_cnt = 0;
   logic [511:0] cur_bits = '0;

   always @(negedge i_ref_clk) begin
      if (chk_en) begin
         if (o_busy === 1'b1) begin
            if (cur_len == 0) cur_gap = idle_cnt;
            if (cur_len < 512) cur_bits[cur_len] = o_tx;
            cur_len++;
         end else begin
            if (cur_len > 0) begin
               frames.push_back('{cur_len, cur_gap, cur_bits});
               cur_len  = 0;
               cur_bits = '0;
               idle_cnt = 0;
            end
            idle_cnt++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge i_ref_clk);
   endtask

   task automatic send(input logic [7:0] div, input logic [7:0] data,
                       input logic pe, input logic pt);
      @(negedge i_ref_clk);
      i_div_ratio  = div;
      i_data       = data;
      i_par_en     = pe;
      i_par_typ    = pt;
      i_data_valid = 1'b1;
      @(negedge i_ref_clk);
      i_data_valid = 1'b0;
   endtask

   task automatic wait_frames(input int n, input string name);
      int t = 0;
      while (frames.size() < n && t < 3000) begin
         @(negedge i_ref_clk);
         t++;
      end
      check({name, "_frames_seen"}, 64'(frames.size() >= n), 64'(1));
   endtask

   task automatic get_frame(output frame_t f);
      if (frames.size() > 0) f = frames.pop_front();
      else f = '{0, 0, '0};
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      int quiet = 0;
      while (quiet < 2 && t < 3000) begin
         @(negedge i_ref_clk);
         quiet = (o_busy === 1'b0) ? quiet + 1 : 0;
         t++;
      end
      check({name, "_idle"}, 64'(quiet >= 2), 64'(1));
   endtask

   function automatic logic [7:0] dec_data(input frame_t f, input int p);
      logic [7:0] d;
      for (int k = 0; k < 8; k++) d[k] = f.bits[p * (k + 1) + p / 2];
      return d;
   endfunction

   function automatic logic [10:0] bit_samples(input frame_t f, input int p);
      logic [10:0] s;
      for (int k = 0; k < 11; k++) s[k] = f.bits[p * k + p / 2];
      return s;
   endfunction

   function automatic bit shape_ok(input frame_t f, input int p, input logic [10:0] pat, input int nb);
      for (int c = 0; c < nb * p; c++) if (f.bits[c] !== pat[c / p]) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      frame_t      f, f2;
      logic [10:0] pat;

      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("rst_tx", 64'(o_tx), 64'(1));
      check("rst_busy", 64'(o_busy), 64'(0));
      i_ret_n = 1'b1;
      tick(3);
      frames.delete();

      // 0xA5, P=4, even parity
      send(8'd4, 8'hA5, 1'b1, PAR_EVEN);
      wait_frames(1, "even");
      get_frame(f);
      pat = 11'b10101001010;
      check("even_len", 64'(f.len), 64'(44));
      check("even_bits", 64'(bit_samples(f, 4)), 64'(pat));
      check("even_shape", 64'(shape_ok(f, 4, pat, 11)), 64'(1));
      wait_idle("even");

      // same frame, odd parity
      send(8'd4, 8'hA5, 1'b1, PAR_ODD);
      wait_frames(1, "odd");
      get_frame(f);
      pat = 11'b11101001010;
      check("odd_len", 64'(f.len), 64'(44));
      check("odd_bits", 64'(bit_samples(f, 4)), 64'(pat));
      check("odd_shape", 64'(shape_ok(f, 4, pat, 11)), 64'(1));
      wait_idle("odd");

      // bypass dividers 0 and 1
      for (int d = 0; d < 2; d++) begin
         send(8'(d), 8'h00, 1'b0, PAR_EVEN);
         wait_frames(1, "bypass");
         get_frame(f);
         check("bypass_len", 64'(f.len), 64'(10));
         check("bypass_bits", 64'(f.bits[9:0]), 64'(10'b1000000000));
         wait_idle("bypass");
      end

      // valid held high, P=2: back-to-back frames, busy-time data edits ignored
      frames.delete();
      @(negedge i_ref_clk);
      i_div_ratio  = 8'd2;
      i_par_en     = 1'b0;
      i_data       = 8'h3C;
      i_data_valid = 1'b1;
      tick(6);
      i_data = 8'hFF;
      tick(3);
      i_data = 8'h81;
      wait_frames(2, "stream");
      i_data_valid = 1'b0;
      i_data       = 8'h55;
      get_frame(f);
      get_frame(f2);
      check("stream_len1", 64'(f.len), 64'(20));
      check("stream_len2", 64'(f2.len), 64'(20));
      check("stream_data1", 64'(dec_data(f, 2)), 64'(8'h3C));
      check("stream_data2", 64'(dec_data(f2, 2)), 64'(8'h81));
      check("stream_gap", 64'(f2.gap), 64'(1));
      wait_idle("stream");
      tick(2);
      frames.delete();

      // reset at cycle 7 of a P=4 frame, then a clean frame
      send(8'd4, 8'hC3, 1'b0, PAR_EVEN);
      tick(6);
      i_ret_n = 1'b0;
      tick(1);
      check("abort_tx", 64'(o_tx), 64'(1));
      check("abort_busy", 64'(o_busy), 64'(0));
      i_ret_n = 1'b1;
      tick(2);
      frames.delete();
      send(8'd4, 8'h5A, 1'b1, PAR_ODD);
      wait_frames(1, "after_rst");
      get_frame(f);
      check("after_rst_len", 64'(f.len), 64'(44));
      check("after_rst_data", 64'(dec_data(f, 4)), 64'(8'h5A));
      check("after_rst_par", 64'(f.bits[38]), 64'(1));
      wait_idle("after_rst");

      // divider and config changed mid-frame only affect the next frame
      frames.delete();
      send(8'd4, 8'h96, 1'b0, PAR_EVEN);
      tick(10);
      i_div_ratio = 8'd8;
      i_par_en    = 1'b1;
      i_par_typ   = PAR_ODD;
      i_data      = 8'h00;
      wait_frames(1, "div_a");
      wait_idle("div_a");
      send(8'd8, 8'h96, 1'b0, PAR_EVEN);
      wait_frames(2, "div_b");
      get_frame(f);
      get_frame(f2);
      check("div4_len", 64'(f.len), 64'(40));
      check("div4_data", 64'(dec_data(f, 4)), 64'(8'h96));
      check("div8_len", 64'(f2.len), 64'(80));
      check("div8_data", 64'(dec_data(f2, 8)), 64'(8'h96));
      wait_idle("div_b");

      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
